cmd_decoder_multi: RTL and testbench
====================================

CMD_DECODER_MULTI -- requirements
Module: cmd_decoder_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of controlled channels (legal 1..10).
REQ-002 SHALL have parameter HDR, default 8'h58 ("X"), giving the frame header byte.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5_000_000, giving the maximum idle cycles between bytes of one frame (legal >= 2).
REQ-004 SHALL have parameter INIT_STATE, NUM_CH bits wide, default all 0, giving the channel reset values.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port po_data, input, 8 bits: received byte, valid when rx_down=1.
REQ-008 SHALL have port rx_down, input, 1 bit: byte strobe; each cycle it is high counts as one byte.
REQ-009 SHALL have port key_state, output, NUM_CH bits: registered channel control levels.
REQ-010 SHALL have port cmd_ok, output, 1 bit: one-cycle pulse on each accepted command.
REQ-011 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on each malformed, timed-out or rejected frame.
REQ-012 SHALL have port resp_data, output, 8 bits: query reply byte, "0" (8'h30) or "1" (8'h31).
REQ-013 SHALL have port resp_valid, output, 1 bit: reply pending; held high until accepted.
REQ-014 SHALL have port resp_ready, input, 1 bit: consumer accept; the reply is taken in any cycle where resp_valid and resp_ready are both 1.

Function
REQ-015 SHALL decode 3-byte frames of the form HDR, channel byte, op byte. The channel byte is "0"+n with n < NUM_CH. The op byte is "1" (set), "0" (clear), "T" (toggle) or "?" (query).
REQ-016 SHALL implement the FSM states IDLE, S_CH and S_OP; all transitions occur only in cycles where rx_down=1, except on timeout and reset.
REQ-017 In IDLE: byte==HDR SHALL go to S_CH; any other byte SHALL be ignored with no cmd_err.
REQ-018 In S_CH: a valid channel byte SHALL latch n and go to S_OP; byte==HDR SHALL stay in S_CH (resync) with no error; any other byte SHALL pulse cmd_err and go to IDLE.
REQ-019 In S_OP, valid op bytes SHALL behave as follows:
- set/clear/toggle: update key_state[n] and pulse cmd_ok, then go to IDLE.
- query: load resp_data="0"+key_state[n], set resp_valid, pulse cmd_ok, then go to IDLE.
REQ-020 In S_OP: byte==HDR SHALL pulse cmd_err and go to S_CH; any other invalid byte SHALL pulse cmd_err and go to IDLE.
REQ-021 Latency: key_state, cmd_ok, cmd_err, resp_data and resp_valid SHALL change in the cycle immediately after the cycle with rx_down=1 that carries the decisive byte (one register stage).
REQ-022 Only the addressed channel bit SHALL change; all other bits SHALL hold.
REQ-023 Timeout counter:
- counts cycles in S_CH and S_OP;
- is cleared on every rx_down and held at 0 in IDLE;
- on reaching TIMEOUT_CYC-1 without rx_down, the FSM SHALL go to IDLE with one cmd_err pulse.
REQ-024 If rx_down=1 in the same cycle the timeout would fire, the byte SHALL take priority and no timeout SHALL occur.
REQ-025 A query while resp_valid=1 and resp_ready=0 SHALL pulse cmd_err instead of cmd_ok and SHALL leave resp_data unchanged.
REQ-026 A query while resp_valid=1 and resp_ready=1 (same cycle) SHALL be accepted: resp_data takes the new value and resp_valid stays 1.
REQ-027 resp_valid SHALL clear in the cycle after a handshake unless REQ-026 applies; resp_data SHALL be stable while resp_valid=1.
REQ-028 Set/clear/toggle commands SHALL be accepted regardless of resp_valid.
REQ-029 cmd_ok and cmd_err SHALL never both be 1 in the same cycle.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set FSM=IDLE, timeout counter=0, key_state=INIT_STATE, cmd_ok=0, cmd_err=0, resp_valid=0 and resp_data=8'h30.
REQ-031 Reset mid-frame SHALL discard the partial frame with no cmd_ok or cmd_err pulse; a byte arriving with rx_down=1 during rst=1 SHALL be ignored.

Verification
REQ-032 Frame "X","2","1", then "X","2","T" -> key_state=4'b0100 one cycle after the third byte with one cmd_ok pulse; after the second frame key_state=4'b0000.
REQ-033 Frame "X","1","?" with resp_ready=0 for 10 cycles -> resp_valid=1 and resp_data=8'h30 held stable; one cycle after resp_ready=1, resp_valid=0.
REQ-034 Frame "X","7","1" with NUM_CH=4 -> cmd_err pulses after byte 2 and key_state is unchanged; a following "X","3","1" -> key_state[3]=1.
REQ-035 With TIMEOUT_CYC=16: send "X","0", then idle 16 cycles -> exactly one cmd_err, FSM back in IDLE; a late "1" byte is ignored and key_state[0]=0.
REQ-036 Send "X","0" then assert rst for one cycle, then send "1" -> key_state=INIT_STATE, no cmd_ok and no cmd_err pulse.
REQ-037 Send "X","X","3","0" with key_state[3]=1 -> resync with no error, key_state[3]=0 and one cmd_ok pulse.

Source files
------------

// File: rtl/cmd_decoder_multi.sv
// cmd_decoder_multi: 3-byte command frame decoder (HDR, channel, op)
// driving NUM_CH registered control levels and a one-byte query reply.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   po_data, rx_down    - received byte and its one-cycle strobe
//   key_state           - registered channel control levels
//   cmd_ok, cmd_err     - one-cycle result pulses per frame
//   resp_data/valid     - query reply ("0"/"1"), held until accepted
//   resp_ready          - reply consumer accept
module cmd_decoder_multi #(
    parameter int                NUM_CH      = 4,
    parameter logic [7:0]        HDR         = 8'h58,
    parameter int                TIMEOUT_CYC = 5_000_000,
    parameter logic [NUM_CH-1:0] INIT_STATE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        po_data,
    input  logic              rx_down,
    output logic [NUM_CH-1:0] key_state,
    output logic              cmd_ok,
    output logic              cmd_err,
    output logic [7:0]        resp_data,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S_CH = 2'd1;
    localparam logic [1:0] S_OP = 2'd2;

    localparam int          TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  CH_LAST  = 8'(8'h30 + NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NUM_CH-1:0] key_q, key_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic ch_valid;
    logic op_set, op_clr, op_tgl, op_qry;
    logic cur_bit;

    assign ch_valid = (po_data >= 8'h30) && (po_data <= CH_LAST);
    assign op_set   = (po_data == 8'h31);
    assign op_clr   = (po_data == 8'h30);
    assign op_tgl   = (po_data == 8'h54);
    assign op_qry   = (po_data == 8'h3F);

    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 4'(i)) cur_bit = key_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tmo_d    = tmo_q;
        key_d    = key_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        // A pending reply drops once the consumer takes it.
        rvalid_d = rvalid_q && !resp_ready;

        if (rx_down) begin
            // A byte always wins over a timeout in the same cycle.
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (po_data == HDR) state_d = S_CH;
                end
                S_CH: begin
                    if (ch_valid) begin
                        // "0".."9" carry the channel index in the low nibble.
                        ch_d    = po_data[3:0];
                        state_d = S_OP;
                    end else if (po_data != HDR) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                S_OP: begin
                    state_d = IDLE;
                    if (op_qry) begin
                        if (rvalid_q && !resp_ready) begin
                            err_d = 1'b1;
                        end else begin
                            rdata_d  = {7'h18, cur_bit};
                            rvalid_d = 1'b1;
                            ok_d     = 1'b1;
                        end
                    end else if (op_set || op_clr || op_tgl) begin
                        ok_d = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_q == 4'(i)) begin
                                key_d[i] = op_set ? 1'b1 :
                                           op_clr ? 1'b0 : !key_q[i];
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                        if (po_data == HDR) state_d = S_CH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            tmo_q    <= '0;
            key_q    <= INIT_STATE;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 8'h30;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            tmo_q    <= tmo_d;
            key_q    <= key_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign key_state  = key_q;
    assign cmd_ok     = ok_q;
    assign cmd_err    = err_q;
    assign resp_data  = rdata_q;
    assign resp_valid = rvalid_q;

endmodule

// File: tb/tb_cmd_decoder_multi.sv
// tb_cmd_decoder_multi: scoreboard bench for cmd_decoder_multi
// (NUM_CH=4, TIMEOUT_CYC=16).
module tb_cmd_decoder_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_down = 1'b0;
    logic       resp_ready = 1'b0;
    logic [7:0] po_data = 8'h00;
    logic [3:0] key_state;
    logic       cmd_ok, cmd_err, resp_valid;
    logic [7:0] resp_data;

    always #5 clk = ~clk;

    cmd_decoder_multi #(
        .NUM_CH(4),
        .HDR(8'h58),
        .TIMEOUT_CYC(16),
        .INIT_STATE(4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .po_data(po_data),
        .rx_down(rx_down),
        .key_state(key_state),
        .cmd_ok(cmd_ok),
        .cmd_err(cmd_err),
        .resp_data(resp_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready)
    );

    typedef struct packed {
        logic       ok;
        logic       err;
        logic [3:0] key;
        logic       rv;
        logic [7:0] rd;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int checks = 0;
    int failures = 0;
    int both_cnt = 0;

    logic [3:0] m_key = 4'b0000;
    logic       m_rv = 1'b0;
    logic [7:0] m_rd = 8'h30;

    always @(negedge clk) begin
        if (cmd_ok && cmd_err) both_cnt++;
        if (!rst && (cmd_ok || cmd_err))
            obs_q.push_back('{cmd_ok, cmd_err, key_state, resp_valid, resp_data});
    end

    // Called at a negedge; returns at the next negedge, when the
    // byte's registered effects are visible.
    task automatic send(input logic [7:0] b);
        po_data = b;
        rx_down = 1'b1;
        @(negedge clk);
        rx_down = 1'b0;
    endtask

    task automatic push(input logic ok);
        exp_q.push_back('{ok, !ok, m_key, m_rv, m_rd});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        po_data = 8'h58;
        rx_down = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_down = 1'b0;
        checks++;
        if ({key_state, cmd_ok, cmd_err, resp_valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=0",
                     {key_state, cmd_ok, cmd_err, resp_valid});
        end
        checks++;
        if (resp_data !== 8'h30) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=30", resp_data);
        end
        // HDR seen during reset must not have opened a frame.
        send(8'h30);
        send(8'h31);
        @(negedge clk);
        checks++;
        if (key_state !== 4'b0000 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_ignore key=%b ev=%0d exp key=0000 ev=0",
                     key_state, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_set_toggle;
        ev_t e, o;
        send(8'h58); send(8'h32); send(8'h31);
        m_key = 4'b0100; push(1'b1);
        checks++;
        if (key_state !== 4'b0100 || cmd_ok !== 1'b1) begin
            failures++;
            $display("FAIL set_latency key=%b ok=%b exp key=0100 ok=1",
                     key_state, cmd_ok);
        end
        send(8'h58); send(8'h32); send(8'h54);
        m_key = 4'b0000; push(1'b1);
        checks++;
        if (key_state !== 4'b0000) begin
            failures++;
            $display("FAIL toggle_key got=%b exp=0000", key_state);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL set_toggle_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL set_toggle_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_query;
        ev_t e, o;
        int bad;
        resp_ready = 1'b0;
        send(8'h58); send(8'h31); send(8'h3F);
        m_rv = 1'b1; m_rd = 8'h30; push(1'b1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== 8'h30) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL query_hold bad_cycles=%0d exp=0", bad);
        end
        // Query while the reply is still pending is rejected.
        send(8'h58); send(8'h30); send(8'h3F);
        push(1'b0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        m_rv = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL query_drop got=%b exp=0", resp_valid);
        end
        send(8'h58); send(8'h31); send(8'h31);
        m_key = 4'b0010; push(1'b1);
        send(8'h58); send(8'h31); send(8'h3F);
        m_rv = 1'b1; m_rd = 8'h31; push(1'b1);
        // Reply accepted in the same cycle as a new query.
        send(8'h58); send(8'h30);
        resp_ready = 1'b1;
        send(8'h3F);
        m_rd = 8'h30; push(1'b1);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h30) begin
            failures++;
            $display("FAIL query_same_cycle rv=%b rd=%h exp rv=1 rd=30",
                     resp_valid, resp_data);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        m_rv = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL query_drop2 got=%b exp=0", resp_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL query_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL query_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_channel;
        ev_t e, o;
        send(8'h58); send(8'h37);
        push(1'b0);
        send(8'h31);
        send(8'h58); send(8'h33); send(8'h31);
        m_key[3] = 1'b1; push(1'b1);
        checks++;
        if (key_state !== 4'b1010) begin
            failures++;
            $display("FAIL bad_ch_key got=%b exp=1010", key_state);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bad_ch_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bad_ch_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout;
        ev_t e, o;
        int early;
        send(8'h58); send(8'h30);
        early = 0;
        repeat (15) begin
            @(negedge clk);
            if (cmd_err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early got=%0d exp=0", early);
        end
        @(negedge clk);
        checks++;
        if (cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire got=%b exp=1", cmd_err);
        end
        push(1'b0);
        send(8'h31);
        @(negedge clk);
        checks++;
        if (key_state[0] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_late got=%b exp=0", key_state[0]);
        end
        // Byte lands on the cycle the timeout would fire.
        send(8'h58); send(8'h30);
        repeat (15) @(negedge clk);
        send(8'h31);
        m_key[0] = 1'b1; push(1'b1);
        send(8'h58); send(8'h30); send(8'h30);
        m_key[0] = 1'b0; push(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL timeout_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midframe;
        send(8'h58); send(8'h30);
        rst = 1'b1;
        po_data = 8'h31;
        rx_down = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_down = 1'b0;
        send(8'h31);
        repeat (2) @(negedge clk);
        m_key = 4'b0000; m_rv = 1'b0; m_rd = 8'h30;
        checks++;
        if (key_state !== 4'b0000 || resp_valid !== 1'b0 || resp_data !== 8'h30) begin
            failures++;
            $display("FAIL midreset_state key=%b rv=%b rd=%h exp 0000 0 30",
                     key_state, resp_valid, resp_data);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_pulses got=%0d exp=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_resync;
        ev_t e, o;
        send(8'h58); send(8'h33); send(8'h31);
        m_key[3] = 1'b1; push(1'b1);
        send(8'h58); send(8'h58); send(8'h33); send(8'h30);
        m_key[3] = 1'b0; push(1'b1);
        checks++;
        if (key_state[3] !== 1'b0) begin
            failures++;
            $display("FAIL resync_key got=%b exp=0", key_state[3]);
        end
        send(8'h58); send(8'h33); send(8'h58);
        push(1'b0);
        send(8'h33); send(8'h31);
        m_key[3] = 1'b1; push(1'b1);
        send(8'h58); send(8'h33); send(8'h30);
        m_key[3] = 1'b0; push(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL resync_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL resync_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        ev_t e, o;
        int ch, op;
        logic [7:0] opb;
        resp_ready = 1'b1;
        for (int n = 0; n < 32; n++) begin
            ch = $urandom_range(0, 3);
            op = $urandom_range(0, 4);
            case (op)
                0: opb = 8'h31;
                1: opb = 8'h30;
                2: opb = 8'h54;
                3: opb = 8'h3F;
                default: opb = 8'h5A;
            endcase
            send(8'h58); send(8'(8'h30 + ch)); send(opb);
            case (op)
                0: begin m_key[ch] = 1'b1; push(1'b1); end
                1: begin m_key[ch] = 1'b0; push(1'b1); end
                2: begin m_key[ch] = !m_key[ch]; push(1'b1); end
                3: begin
                    m_rv = 1'b1; m_rd = {7'h18, m_key[ch]};
                    push(1'b1); m_rv = 1'b0;
                end
                default: push(1'b0);
            endcase
        end
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (key_state !== m_key) begin
            failures++;
            $display("FAIL b2b_key got=%b exp=%b", key_state, m_key);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_ev got=%h exp=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL ok_err_both got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_set_toggle;
        test_query;
        test_bad_channel;
        test_timeout;
        test_reset_midframe;
        test_resync;
        test_back_to_back;
        test_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
